leading_one_normalizer: RTL and testbench

- Sequential left-normalizer for 16-bit unsigned operands.
- Loads an operand and shifts it left one bit per cycle until the MSB is 1.
- Reports the normalized value and the shift count, i.e. the leading-zero count.
- Sits downstream of the operand shift-register stage and feeds the log/approximate-multiply datapath. Uses a start/done handshake toward the datapath controller.

---
 rtl/leading_one_normalizer.sv | 108 ++++++++++
 tb/tb_leading_one_normalizer.sv | 138 +++++++++++++
 2 files changed

// File: rtl/leading_one_normalizer.sv
// leading_one_normalizer
//   Sequential left-normalizer. On an accepted start the operand is loaded and
//   shifted left one bit per cycle until its MSB is set. The number of shifts
//   taken is the leading-zero count. An all-zero operand is flagged instead of
//   being shifted.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      request pulse, only honoured while idle
//   data_in    operand, captured on the edge that accepts start
//   busy       high while an operation is in flight or completing
//   done       single-cycle completion pulse
//   norm_out   working / normalized value; final from done onward
//   shift_cnt  number of left shifts performed (leading-zero count)
//   zero       operand was all zeros; valid from done onward
//   msb_out    norm_out[WIDTH-1]
module leading_one_normalizer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] norm_out,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             zero,
  output logic             msb_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   norm_q,  norm_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               zero_q,  zero_d;
  logic               done_q,  done_d;
  logic               busy_q,  busy_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      norm_q  <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      norm_q  <= norm_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    norm_d  = norm_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          norm_d  = data_in;
          cnt_d   = '0;
          zero_d  = 1'b0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // Zero test takes priority so an empty operand never shifts; a
        // nonzero operand needs at most WIDTH-1 shifts, so cnt cannot wrap.
        if (norm_q == '0) begin
          zero_d  = 1'b1;
          state_d = S_DONE;
        end else if (norm_q[WIDTH-1]) begin
          state_d = S_DONE;
        end else begin
          norm_d = {norm_q[WIDTH-2:0], 1'b0};
          cnt_d  = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;  // start here is deliberately dropped
      default: state_d = S_IDLE;
    endcase
    // Flags are registered from the next state so they line up exactly with
    // the state register (Moore outputs without a decode after the flop).
    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign norm_out  = norm_q;
  assign shift_cnt = cnt_q;
  assign zero      = zero_q;
  assign msb_out   = norm_q[WIDTH-1];

endmodule

// File: tb/tb_leading_one_normalizer.sv
module tb_leading_one_normalizer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] data_in = '0;
  logic        busy, done, zero, msb_out;
  logic [15:0] norm_out;
  logic [3:0]  shift_cnt;

  leading_one_normalizer #(.WIDTH(16), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in),
    .busy(busy), .done(done), .norm_out(norm_out),
    .shift_cnt(shift_cnt), .zero(zero), .msb_out(msb_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] norm;
    logic [3:0]  cnt;
    logic        z;
    int          cyc;   // cycle count at which done must be observed
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("norm_out",  {16'd0, norm_out},  {16'd0, e.norm});
        chk("shift_cnt", {28'd0, shift_cnt}, {28'd0, e.cnt});
        chk("zero",      {31'd0, zero},      {31'd0, e.z});
        chk("msb_out",   {31'd0, msb_out},   {31'd0, e.norm[15]});
        chk("latency",   cyc,                e.cyc);
      end
    end
  end

  // Issue one operation. shifts is the hand-computed leading-zero count; the
  // done edge is accept edge + shifts + 1. inj pokes start/FFFF mid-shift and
  // during DONE, both of which must be ignored.
  task automatic run(input logic [15:0] d, input logic [15:0] en,
                     input logic [3:0] ec, input logic ez, input bit inj);
    int n;
    @(negedge clk);
    start   = 1'b1;
    data_in = d;
    q.push_back('{norm: en, cnt: ec, z: ez, cyc: cyc + 2 + int'(ec)});
    @(negedge clk);
    start   = 1'b0;
    data_in = 16'($urandom);
    n = 0;
    while (!done && n < 40) begin
      chk("busy_during_op", {31'd0, busy}, 32'd1);
      if (inj && n == 3) begin
        start = 1'b1; data_in = 16'hFFFF;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_timeout", 32'd0, 32'd1);
    if (inj) begin
      start = 1'b1; data_in = 16'hFFFF;
    end
    @(negedge clk);
    start = 1'b0;
    chk("done_single", {31'd0, done}, 32'd0);
    chk("idle_busy",   {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    chk("hold_norm", {16'd0, norm_out},  {16'd0, en});
    chk("hold_cnt",  {28'd0, shift_cnt}, {28'd0, ec});
    chk("hold_zero", {31'd0, zero},      {31'd0, ez});
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_norm", {16'd0, norm_out}, 32'd0);
    chk("rst_cnt",  {28'd0, shift_cnt}, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run(16'h8000, 16'h8000, 4'd0,  1'b0, 1'b0);
    run(16'h0001, 16'h8000, 4'd15, 1'b0, 1'b1);  // busy rejection
    run(16'hFFFF, 16'hFFFF, 4'd0,  1'b0, 1'b0);
    run(16'h0350, 16'hD400, 4'd6,  1'b0, 1'b0);
    run(16'h0000, 16'h0000, 4'd0,  1'b1, 1'b0);
    run(16'h00F0, 16'hF000, 4'd8,  1'b0, 1'b0);
    run(16'h4001, 16'h8002, 4'd1,  1'b0, 1'b0);

    // Reset mid-operation: no expectation queued, so any done is flagged.
    @(negedge clk);
    start = 1'b1; data_in = 16'h0004;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_norm", {16'd0, norm_out}, 32'd0);
    chk("abort_cnt",  {28'd0, shift_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_no_done_busy", {31'd0, busy}, 32'd0);
    run(16'h0004, 16'h8000, 4'd13, 1'b0, 1'b0);

    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    chk("scoreboard_empty", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
